i2s_frame_sequencer: RTL and testbench
======================================

// Module: i2s_frame_sequencer
// PURPOSE
//   Master timing sequencer for the dual-channel I2S receive/mix datapath. Generates ws from sck,
//   frames left/right slots, pulses per-slot completion strobes, and owns the mixer channel_sel
//   setting. New slot length and channel_sel arrive over a valid/ready config port; they are applied
//   only at a frame boundary, so the datapath never sees a mid-frame change.
// PARAMETERS
//   SLOT_W       5    width of slot-length and bit-index fields
//   DEF_SLOT     24   slot length (sck cycles per channel) after reset
//   MIN_SLOT     8    smallest legal slot length; smaller requests clamp to this
//   MAX_SLOT     24   largest legal slot length; larger requests clamp to this
//   FRAME_W      8    width of frame counter
// PORTS
//   sck            in   1        sole clock; all state updates on posedge
//   reset          in   1        synchronous, active-low reset (0 = reset)
//   en             in   1        run request; level-sensitive
//   cfg_valid      in   1        config offer
//   cfg_ready      out  1        config accept; transfer when cfg_valid & cfg_ready
//   cfg_slot_len   in   SLOT_W   requested slot length
//   cfg_chan_sel   in   2        requested mix select (00 mute, 01 c1, 10 c2, 11 c1+c2)
//   ws             out  1        word select: 0 = left slot, 1 = right slot
//   bit_idx        out  SLOT_W   position inside current slot, 0..slot_len-1
//   frame_start    out  1        1-cycle pulse on first cycle of every frame
//   left_done      out  1        1-cycle pulse on last cycle of left slot
//   right_done     out  1        1-cycle pulse on last cycle of right slot
//   chan_sel       out  2        active mix select driven to datapath
//   frame_cnt      out  FRAME_W  completed-frame count, wraps to 0
//   busy           out  1        1 in RUN or STOP
// BEHAVIOUR
//   Reset (reset==0 at posedge): state=IDLE, ws=0, bit_idx=0, all pulses 0, frame_cnt=0,
//     slot_len=DEF_SLOT, chan_sel=2'b01, pending empty, cfg_ready=1, busy=0.
//   States: IDLE, RUN, STOP (finishing current frame after en drops).
//   IDLE: ws=0, bit_idx=0. en=1 -> RUN next cycle; that cycle has frame_start=1, bit_idx=0, ws=0.
//   RUN: bit_idx increments each cycle. At bit_idx==slot_len-1: bit_idx->0, ws toggles; if ws==0
//     left_done=1 that cycle; if ws==1 right_done=1 that cycle (frame end).
//   Frame end (right_done cycle): frame_cnt++ (wraps at 2^FRAME_W-1 -> 0); pending config copied to
//     slot_len/chan_sel, taking effect on the next cycle (first of new frame); pending cleared.
//     Next cycle: frame_start=1 if continuing, else IDLE.
//   en=0 in RUN -> STOP; STOP counts exactly as RUN; at frame end -> IDLE. en=1 during STOP -> RUN,
//     no gap. en is never acted on mid-frame: a frame, once started, always completes.
//   Frame length = 2*slot_len cycles; frame_start period = 2*slot_len with en held high.
//   Config: cfg_ready = ~pending_valid. One-entry pending register; second offer stalls until apply.
//     Accept in IDLE: applied on the next cycle, pending not held. Simultaneous accept and frame end:
//     the accepted value goes to pending (applies at following frame end); existing pending applies now.
//   Clamp on accept: cfg_slot_len<MIN_SLOT -> MIN_SLOT; >MAX_SLOT -> MAX_SLOT.
//   Reset mid-frame: all state returns to reset values on that edge; pending config discarded.
//   ws, bit_idx, strobes, chan_sel are registered outputs (no combinational path from inputs).
// TESTING
//   1. reset=0 2 cycles, en=1 -> frame_start at cycle 0, left_done at 23, ws=1 at 24,
//      right_done at 47, frame_start at 48, frame_cnt=1.
//   2. cfg slot_len=16, chan_sel=11 mid-frame -> cfg_ready drops; current frame stays 48 cycles;
//      next frame is 32 cycles with chan_sel=11; cfg_ready=1 again.
//   3. cfg slot_len=3 then 31 -> slot_len becomes 8 (16-cycle frame), then 24 (48-cycle frame).
//   4. en=0 at bit 5 of left slot -> frame completes, right_done fires, then IDLE, ws=0, busy=0.
//      Re-raise en during STOP -> frames continue back-to-back.
//   5. reset=0 at bit 10 of right slot -> next cycle ws=0, bit_idx=0, chan_sel=01, pending cleared.
//   6. Run 256 frames -> frame_cnt wraps 255->0 on the 256th right_done.

Source files
------------

// File: rtl/i2s_frame_sequencer.sv
// I2S frame timing sequencer: derives ws/bit_idx from sck, frames left/right slots,
// and swaps slot length / mix select only on frame boundaries.
module i2s_frame_sequencer #(
    parameter int SLOT_W   = 5,
    parameter int DEF_SLOT = 24,
    parameter int MIN_SLOT = 8,
    parameter int MAX_SLOT = 24,
    parameter int FRAME_W  = 8
) (
    input  logic               sck,
    input  logic               reset,
    input  logic               en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [SLOT_W-1:0]  cfg_slot_len,
    input  logic [1:0]         cfg_chan_sel,
    output logic               ws,
    output logic [SLOT_W-1:0]  bit_idx,
    output logic               frame_start,
    output logic               left_done,
    output logic               right_done,
    output logic [1:0]         chan_sel,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STOP = 2'd2;
    localparam logic [SLOT_W-1:0] ONE = SLOT_W'(1);

    logic [1:0]         r_state;
    logic               r_ws;
    logic [SLOT_W-1:0]  r_bit;
    logic [SLOT_W-1:0]  r_slot;
    logic [1:0]         r_chan;
    logic               r_pend_vld;
    logic [SLOT_W-1:0]  r_pend_slot;
    logic [1:0]         r_pend_chan;
    logic               r_fs;
    logic               r_ld;
    logic               r_rd;
    logic [FRAME_W-1:0] r_fcnt;

    logic [1:0]         w_state_nx;
    logic               w_ws_nx;
    logic [SLOT_W-1:0]  w_bit_nx;
    logic [SLOT_W-1:0]  w_slot_nx;
    logic [1:0]         w_chan_nx;
    logic               w_pend_vld_nx;
    logic [SLOT_W-1:0]  w_pend_slot_nx;
    logic [1:0]         w_pend_chan_nx;
    logic               w_fs_nx;
    logic [FRAME_W-1:0] w_fcnt_nx;
    logic               w_accept;
    logic               w_last;
    logic               w_frame_end;
    logic               w_busy_nx;
    logic               w_last_nx;
    logic [SLOT_W-1:0]  w_cfg_clamped;

    function automatic logic [SLOT_W-1:0] clamp_slot(input logic [SLOT_W-1:0] v);
        if (v < SLOT_W'(MIN_SLOT)) return SLOT_W'(MIN_SLOT);
        if (v > SLOT_W'(MAX_SLOT)) return SLOT_W'(MAX_SLOT);
        return v;
    endfunction

    assign w_accept      = cfg_valid & ~r_pend_vld;
    assign w_cfg_clamped = clamp_slot(cfg_slot_len);
    assign w_last        = (r_bit == r_slot - ONE);
    assign w_frame_end   = (r_state != S_IDLE) & r_ws & w_last;

    always_comb begin
        w_state_nx     = r_state;
        w_ws_nx        = r_ws;
        w_bit_nx       = r_bit;
        w_slot_nx      = r_slot;
        w_chan_nx      = r_chan;
        w_pend_vld_nx  = r_pend_vld;
        w_pend_slot_nx = r_pend_slot;
        w_pend_chan_nx = r_pend_chan;
        w_fs_nx        = 1'b0;
        w_fcnt_nx      = r_fcnt;
        if (r_state == S_IDLE) begin
            w_ws_nx  = 1'b0;
            w_bit_nx = '0;
            // A pending entry left over from a frame-end accept drains here; accept is blocked then.
            if (r_pend_vld) begin
                w_slot_nx     = r_pend_slot;
                w_chan_nx     = r_pend_chan;
                w_pend_vld_nx = 1'b0;
            end
            if (w_accept) begin
                w_slot_nx = w_cfg_clamped;
                w_chan_nx = cfg_chan_sel;
            end
            if (en) begin
                w_state_nx = S_RUN;
                w_fs_nx    = 1'b1;
            end
        end else begin
            if (w_last) begin
                w_bit_nx = '0;
                w_ws_nx  = ~r_ws;
            end else begin
                w_bit_nx = r_bit + ONE;
            end
            if (w_frame_end) begin
                w_fcnt_nx = r_fcnt + FRAME_W'(1);
                if (r_pend_vld) begin
                    w_slot_nx     = r_pend_slot;
                    w_chan_nx     = r_pend_chan;
                    w_pend_vld_nx = 1'b0;
                end
                w_state_nx = en ? S_RUN : S_IDLE;
                w_fs_nx    = en;
            end else begin
                w_state_nx = en ? S_RUN : S_STOP;
            end
            // Accepted after the apply above, so a same-cycle offer waits for the next frame end.
            if (w_accept) begin
                w_pend_vld_nx  = 1'b1;
                w_pend_slot_nx = w_cfg_clamped;
                w_pend_chan_nx = cfg_chan_sel;
            end
        end
    end

    assign w_busy_nx = (w_state_nx != S_IDLE);
    assign w_last_nx = (w_bit_nx == w_slot_nx - ONE);

    always_ff @(posedge sck) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_ws        <= 1'b0;
            r_bit       <= '0;
            r_slot      <= SLOT_W'(DEF_SLOT);
            r_chan      <= 2'b01;
            r_pend_vld  <= 1'b0;
            r_pend_slot <= '0;
            r_pend_chan <= '0;
            r_fs        <= 1'b0;
            r_ld        <= 1'b0;
            r_rd        <= 1'b0;
            r_fcnt      <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_ws        <= w_ws_nx;
            r_bit       <= w_bit_nx;
            r_slot      <= w_slot_nx;
            r_chan      <= w_chan_nx;
            r_pend_vld  <= w_pend_vld_nx;
            r_pend_slot <= w_pend_slot_nx;
            r_pend_chan <= w_pend_chan_nx;
            r_fs        <= w_fs_nx;
            r_ld        <= w_busy_nx & ~w_ws_nx & w_last_nx;
            r_rd        <= w_busy_nx & w_ws_nx & w_last_nx;
            r_fcnt      <= w_fcnt_nx;
        end
    end

    assign cfg_ready   = ~r_pend_vld;
    assign ws          = r_ws;
    assign bit_idx     = r_bit;
    assign frame_start = r_fs;
    assign left_done   = r_ld;
    assign right_done  = r_rd;
    assign chan_sel    = r_chan;
    assign frame_cnt   = r_fcnt;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// Bench for i2s_frame_sequencer: directed scenarios plus random traffic against a
// frame-position reference model.
module tb_i2s_frame_sequencer;

    logic       sck = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [4:0] cfg_slot_len = '0;
    logic [1:0] cfg_chan_sel = '0;
    logic       ws;
    logic [4:0] bit_idx;
    logic       frame_start;
    logic       left_done;
    logic       right_done;
    logic [1:0] chan_sel;
    logic [7:0] frame_cnt;
    logic       busy;
    logic [20:0] dut_vec;

    int total = 0;
    int bad = 0;

    // Reference model: a frame is a position 0..2*slot-1 rather than ws/bit_idx.
    bit m_active;
    int m_pos, m_slot, m_chan, m_fcnt;
    bit m_pend;
    int m_pslot, m_pchan;

    i2s_frame_sequencer #(
        .SLOT_W(5), .DEF_SLOT(24), .MIN_SLOT(8), .MAX_SLOT(24), .FRAME_W(8)
    ) dut (
        .sck(sck), .reset(reset), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_slot_len(cfg_slot_len), .cfg_chan_sel(cfg_chan_sel), .ws(ws), .bit_idx(bit_idx),
        .frame_start(frame_start), .left_done(left_done), .right_done(right_done),
        .chan_sel(chan_sel), .frame_cnt(frame_cnt), .busy(busy)
    );

    assign dut_vec = {cfg_ready, busy, ws, bit_idx, frame_start, left_done, right_done,
                      chan_sel, frame_cnt};

    always #5 sck = ~sck;

    function automatic int clampm(input int v);
        if (v < 8) return 8;
        if (v > 24) return 24;
        return v;
    endfunction

    task automatic model_edge();
        bit acc;
        if (!reset) begin
            m_active = 0; m_pos = 0; m_slot = 24; m_chan = 1; m_fcnt = 0; m_pend = 0;
            return;
        end
        acc = cfg_valid && !m_pend;
        if (!m_active) begin
            if (m_pend) begin m_slot = m_pslot; m_chan = m_pchan; m_pend = 0; end
            if (acc) begin m_slot = clampm(int'(cfg_slot_len)); m_chan = int'(cfg_chan_sel); end
            if (en) begin m_active = 1; m_pos = 0; end
        end else begin
            if (m_pos == 2 * m_slot - 1) begin
                m_fcnt = (m_fcnt + 1) % 256;
                if (m_pend) begin m_slot = m_pslot; m_chan = m_pchan; m_pend = 0; end
                m_pos = 0;
                m_active = en;
            end else begin
                m_pos++;
            end
            if (acc) begin
                m_pend = 1; m_pslot = clampm(int'(cfg_slot_len)); m_pchan = int'(cfg_chan_sel);
            end
        end
    endtask

    function automatic logic [20:0] exp_vec();
        logic e_ws, e_fs, e_ld, e_rd;
        int e_bit;
        if (!m_active) begin
            e_ws = 0; e_bit = 0; e_fs = 0; e_ld = 0; e_rd = 0;
        end else begin
            e_ws  = (m_pos >= m_slot);
            e_bit = m_pos % m_slot;
            e_fs  = (m_pos == 0);
            e_ld  = (m_pos == m_slot - 1);
            e_rd  = (m_pos == 2 * m_slot - 1);
        end
        return {~m_pend, m_active, e_ws, 5'(e_bit), e_fs, e_ld, e_rd, 2'(m_chan), 8'(m_fcnt)};
    endfunction

    task automatic tick();
        @(posedge sck);
        model_edge();
        #2;
    endtask

    task automatic run_to_fs(input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if (frame_start) begin n = i; break; end
        end
    endtask

    task automatic test_reset();
        reset = 0; en = 0; cfg_valid = 0;
        tick(); tick();
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL reset_vec got=%h exp=%h", dut_vec, exp_vec());
        end
        total++;
        if ({busy, cfg_ready, ws, bit_idx, chan_sel, frame_cnt} !== {1'b0, 1'b1, 1'b0, 5'd0, 2'b01, 8'd0}) begin
            bad++; $display("FAIL reset_state busy=%b rdy=%b ws=%b bit=%0d chan=%b fcnt=%0d exp 0,1,0,0,01,0",
                            busy, cfg_ready, ws, bit_idx, chan_sel, frame_cnt);
        end
    endtask

    task automatic test_basic_frame();
        reset = 1; en = 1;
        for (int c = 0; c <= 48; c++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL basic_vec cyc=%0d got=%h exp=%h", c, dut_vec, exp_vec());
            end
            if (c == 0) begin
                total++;
                if (frame_start !== 1'b1 || bit_idx !== 5'd0 || ws !== 1'b0) begin
                    bad++; $display("FAIL basic_start fs=%b bit=%0d ws=%b exp 1,0,0", frame_start, bit_idx, ws);
                end
            end
            if (c == 23) begin
                total++;
                if (left_done !== 1'b1) begin bad++; $display("FAIL basic_left_done got=%b exp=1", left_done); end
            end
            if (c == 24) begin
                total++;
                if (ws !== 1'b1) begin bad++; $display("FAIL basic_ws got=%b exp=1", ws); end
            end
            if (c == 47) begin
                total++;
                if (right_done !== 1'b1) begin bad++; $display("FAIL basic_right_done got=%b exp=1", right_done); end
            end
            if (c == 48) begin
                total++;
                if (frame_start !== 1'b1 || frame_cnt !== 8'd1) begin
                    bad++; $display("FAIL basic_frame2 fs=%b fcnt=%0d exp 1,1", frame_start, frame_cnt);
                end
            end
        end
    endtask

    task automatic test_cfg_midframe();
        int n;
        repeat (4) tick();
        cfg_valid = 1; cfg_slot_len = 5'd16; cfg_chan_sel = 2'b11;
        tick();
        cfg_valid = 0;
        total++;
        if (cfg_ready !== 1'b0) begin bad++; $display("FAIL cfg_ready_drop got=%b exp=0", cfg_ready); end
        run_to_fs(100, n);
        total++;
        if (n != 43) begin bad++; $display("FAIL cfg_old_frame cycles=%0d exp=43", n); end
        total++;
        if (chan_sel !== 2'b11 || cfg_ready !== 1'b1) begin
            bad++; $display("FAIL cfg_applied chan=%b rdy=%b exp 11,1", chan_sel, cfg_ready);
        end
        run_to_fs(100, n);
        total++;
        if (n != 32) begin bad++; $display("FAIL cfg_new_frame cycles=%0d exp=32", n); end
    endtask

    task automatic test_clamp();
        int n;
        cfg_valid = 1; cfg_slot_len = 5'd3; cfg_chan_sel = 2'b10;
        tick();
        cfg_valid = 0;
        run_to_fs(100, n);
        run_to_fs(100, n);
        total++;
        if (n != 16) begin bad++; $display("FAIL clamp_min cycles=%0d exp=16", n); end
        cfg_valid = 1; cfg_slot_len = 5'd31; cfg_chan_sel = 2'b01;
        tick();
        cfg_valid = 0;
        run_to_fs(100, n);
        run_to_fs(100, n);
        total++;
        if (n != 48) begin bad++; $display("FAIL clamp_max cycles=%0d exp=48", n); end
    endtask

    task automatic test_stop();
        int n;
        bit seen_rd;
        repeat (5) tick();
        en = 0;
        seen_rd = 0;
        for (int i = 1; i <= 42; i++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL stop_vec i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            if (right_done) seen_rd = 1;
        end
        total++;
        if (!seen_rd || busy !== 1'b1) begin
            bad++; $display("FAIL stop_finish right_done_seen=%0d busy=%b exp 1,1", seen_rd, busy);
        end
        tick();
        total++;
        if (busy !== 1'b0 || ws !== 1'b0 || frame_start !== 1'b0) begin
            bad++; $display("FAIL stop_idle busy=%b ws=%b fs=%b exp 0,0,0", busy, ws, frame_start);
        end
        en = 1;
        tick();
        total++;
        if (frame_start !== 1'b1) begin bad++; $display("FAIL restart_fs got=%b exp=1", frame_start); end
        repeat (10) tick();
        en = 0;
        repeat (5) tick();
        en = 1;
        run_to_fs(100, n);
        total++;
        if (n != 33) begin bad++; $display("FAIL stop_rerun cycles=%0d exp=33", n); end
    endtask

    task automatic test_reset_mid();
        int n;
        cfg_valid = 1; cfg_slot_len = 5'd10; cfg_chan_sel = 2'b10;
        tick();
        cfg_valid = 0;
        repeat (33) tick();
        total++;
        if (ws !== 1'b1 || bit_idx !== 5'd10 || cfg_ready !== 1'b0) begin
            bad++; $display("FAIL rstmid_pos ws=%b bit=%0d rdy=%b exp 1,10,0", ws, bit_idx, cfg_ready);
        end
        reset = 0;
        tick();
        reset = 1;
        total++;
        if ({ws, bit_idx, chan_sel, cfg_ready, busy, frame_cnt} !== {1'b0, 5'd0, 2'b01, 1'b1, 1'b0, 8'd0}) begin
            bad++; $display("FAIL rstmid_state ws=%b bit=%0d chan=%b rdy=%b busy=%b fcnt=%0d exp 0,0,01,1,0,0",
                            ws, bit_idx, chan_sel, cfg_ready, busy, frame_cnt);
        end
        tick();
        run_to_fs(100, n);
        total++;
        if (n != 48) begin bad++; $display("FAIL rstmid_discard cycles=%0d exp=48", n); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 199) != 0);
            en           = ($urandom_range(0, 9) != 0);
            cfg_valid    = ($urandom_range(0, 15) == 0);
            cfg_slot_len = 5'($urandom_range(0, 31));
            cfg_chan_sel = 2'($urandom_range(0, 3));
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL random_vec i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        reset = 1; cfg_valid = 0;
    endtask

    task automatic test_wrap();
        int rd_cnt;
        bit done;
        reset = 0; en = 0; cfg_valid = 0;
        tick();
        reset = 1; cfg_valid = 1; cfg_slot_len = 5'd8; cfg_chan_sel = 2'b01;
        tick();
        cfg_valid = 0; en = 1;
        rd_cnt = 0; done = 0;
        for (int i = 0; i < 256 * 16 + 100 && !done; i++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++; $display("FAIL wrap_vec i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
            if (right_done) begin
                rd_cnt++;
                if (rd_cnt == 256) begin
                    total++;
                    if (frame_cnt !== 8'd255) begin bad++; $display("FAIL wrap_pre fcnt=%0d exp=255", frame_cnt); end
                    tick();
                    total++;
                    if (frame_cnt !== 8'd0) begin bad++; $display("FAIL wrap_post fcnt=%0d exp=0", frame_cnt); end
                    done = 1;
                end
            end
        end
        total++;
        if (!done) begin bad++; $display("FAIL wrap_timeout right_done=%0d exp=256", rd_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_cfg_midframe();
        test_clamp();
        test_stop();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
